// File: rtl/mem_req_ctrl_if.sv
// Bundled command, memory-port and response signals for mem_req_ctrl.
// slave = the controller side, master = the producer/memory/consumer side.
interface mem_req_ctrl_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr_en;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, mem_rdata, rsp_ready,
        output req_ready, mem_addr, mem_wr_en, mem_rd_en, mem_wdata,
               rsp_valid, rsp_data, rsp_err
    );

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, mem_rdata, rsp_ready,
        input  req_ready, mem_addr, mem_wr_en, mem_rd_en, mem_wdata,
               rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/mem_req_ctrl.sv
// Memory request front-end: registered issue stage, read-pending stage and a credit-protected FWFT response FIFO.
// Optional macro MEM_ADDR_CHECK_EN: out-of-range addresses skip the memory and return rsp_err=1 for reads.
module mem_req_ctrl #(
    parameter int ADDR_W    = 2,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_req_ctrl_if.slave bus
);
    localparam int PTR_W  = $clog2(RSP_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int USED_W = PTR_W + 2;
    localparam logic [USED_W-1:0] DEPTH_U = USED_W'(RSP_DEPTH);

    if (RSP_DEPTH < 2 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0 || MEM_DEPTH < 1) begin : g_bad_cfg
        $error("mem_req_ctrl: RSP_DEPTH must be a power of 2 >= 2 and MEM_DEPTH >= 1");
    end

    logic              run_q, run_d;
    logic              mem_wr_en_q, mem_wr_en_d;
    logic              mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              s1_rd_q, s1_rd_d;
    logic              s2_rd_q, s2_rd_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] fifo_data_q [RSP_DEPTH];

    logic [USED_W-1:0] used;
    logic              req_ready;
    logic              accept;
    logic              addr_ok;
    logic              push;
    logic              pop;
    logic              rsp_valid;
    logic [DATA_W-1:0] push_data;

`ifdef MEM_ADDR_CHECK_EN
    localparam logic [ADDR_W:0] MEM_DEPTH_W = (ADDR_W + 1)'(MEM_DEPTH);
    logic s1_err_q, s1_err_d;
    logic s2_err_q, s2_err_d;
    logic fifo_err_q [RSP_DEPTH];

    assign addr_ok = ({1'b0, bus.req_addr} < MEM_DEPTH_W);
    // An errored read never touched the memory, so its captured word is forced to zero.
    assign push_data = s2_err_q ? '0 : bus.mem_rdata;
`else
    assign addr_ok   = 1'b1;
    assign push_data = bus.mem_rdata;
`endif

    // Credits: every read in S1/S2 already owns a FIFO slot, so overflow cannot happen.
    always_comb begin
        used      = USED_W'(count_q) + USED_W'(s1_rd_q) + USED_W'(s2_rd_q);
        req_ready = run_q && (used < DEPTH_U);
        accept    = bus.req_valid && req_ready;
        rsp_valid = (count_q != '0);
        pop       = rsp_valid && bus.rsp_ready;
        push      = s2_rd_q;
    end

    always_comb begin
        run_d       = 1'b1;
        mem_wr_en_d = accept &&  bus.req_wr && addr_ok;
        mem_rd_en_d = accept && !bus.req_wr && addr_ok;
        mem_addr_d  = accept ? bus.req_addr  : mem_addr_q;
        mem_wdata_d = accept ? bus.req_wdata : mem_wdata_q;
        s1_rd_d     = accept && !bus.req_wr;
        s2_rd_d     = s1_rd_q;
        wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d     = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q       <= 1'b0;
            mem_wr_en_q <= 1'b0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            s1_rd_q     <= 1'b0;
            s2_rd_q     <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            run_q       <= run_d;
            mem_wr_en_q <= mem_wr_en_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            s1_rd_q     <= s1_rd_d;
            s2_rd_q     <= s2_rd_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while count_q says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= push_data;
        end
    end

`ifdef MEM_ADDR_CHECK_EN
    always_comb begin
        s1_err_d = accept && !bus.req_wr && !addr_ok;
        s2_err_d = s1_err_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_err_q <= 1'b0;
            s2_err_q <= 1'b0;
        end else begin
            s1_err_q <= s1_err_d;
            s2_err_q <= s2_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_err_q[wr_ptr_q] <= s2_err_q;
        end
    end

    assign bus.rsp_err = rsp_valid ? fifo_err_q[rd_ptr_q] : 1'b0;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.req_ready = req_ready;
    assign bus.mem_wr_en = mem_wr_en_q;
    assign bus.mem_rd_en = mem_rd_en_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = rsp_valid ? fifo_data_q[rd_ptr_q] : '0;
endmodule
